// File: rtl/imm_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : imm_pkg
//  Purpose  : Shared types and decode helper for the RV32I immediate queue.
//             Provides the immediate-format enum, base opcode constants and
//             imm_decode(), which maps a raw instruction word to
//             {fmt, illegal, imm32}.
//  Contents : fmt_t, dec_t, OP_* opcode localparams, imm_decode()
//  Revision : 1.0  initial release
// =============================================================================
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_R    = 3'd6
   } fmt_t;

   // Packed so that the bit layout is {fmt, illegal, imm32}.
   typedef struct packed {
      fmt_t        fmt;
      logic        illegal;
      logic [31:0] imm;
   } dec_t;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   // Every format places the sign at instr[31], so imm[31] always equals the
   // instruction sign bit for formats that carry an immediate.
   function automatic dec_t imm_decode(input logic [31:0] instr);
      dec_t d;
      d.fmt     = FMT_NONE;
      d.illegal = 1'b0;
      d.imm     = 32'h0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
            d.fmt = FMT_I;
            d.imm = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            d.fmt = FMT_S;
            d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            d.fmt = FMT_B;
            d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            d.fmt = FMT_U;
            d.imm = {instr[31:12], 12'h000};
         end
         OP_JAL: begin
            d.fmt = FMT_J;
            d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
         end
         OP_REG: begin
            d.fmt = FMT_R;
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_fifo.sv
`default_nettype none
// =============================================================================
//  Module   : imm_fifo
//  Purpose  : Generic synchronous valid/ready FIFO with synchronous flush.
//             Ready/valid are functions of registered state only, so a full
//             FIFO refuses a push even when it is popped in the same cycle.
//             While empty, o_rd_data holds the last head that was presented.
//  Ports    : clk, rst_n (async, active-low), i_flush,
//             i_wr_valid / o_wr_ready / i_wr_data   (write side)
//             o_rd_valid / i_rd_ready / o_rd_data   (read side)
//  Revision : 1.0  initial release
// =============================================================================
module imm_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_wr_valid,
   output logic         o_wr_ready,
   input  logic [W-1:0] i_wr_data,
   output logic         o_rd_valid,
   input  logic         i_rd_ready,
   output logic [W-1:0] o_rd_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [W-1:0]  r_mem [DEPTH];
   logic [W-1:0]  r_last;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push     = i_wr_valid && !w_full;
   assign w_pop      = i_rd_ready && !w_empty;
   assign o_wr_ready = !w_full;
   assign o_rd_valid = !w_empty;
   // Empty queue shows the last presented head (zero after reset).
   assign o_rd_data  = w_empty ? r_last : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
      end else begin
         if (!w_empty) begin
            r_last <= r_mem[r_rd_ptr];
         end
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            // DEPTH is a power of two, so pointer increment wraps naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Storage needs no reset: it is only observed while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imm_decode_q.sv
`default_nettype none
// =============================================================================
//  Module   : imm_decode_q
//  Purpose  : RV32I immediate decoder (I/S/B/U/J, R as zero-imm, illegal flag)
//             buffered through a DEPTH-entry valid/ready queue. Decode is done
//             on the input word and stored at push; one cycle latency.
//  Ports    : sysclk, rst_n (async, active-low), flush,
//             in_valid / in_ready / in_instr[31:0],
//             out_valid / out_ready / out_imm[XLEN-1:0] / out_fmt /
//             out_illegal / out_instr[31:0]
//             illegal_cnt[15:0] only when IMM_ILLEGAL_CNT_EN is defined
//  Config   : IMM_ILLEGAL_CNT_EN - adds saturating count of illegal pushes
//  Revision : 1.0  initial release
// =============================================================================
module imm_decode_q
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            sysclk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output fmt_t            out_fmt,
   output logic            out_illegal,
   output logic [31:0]     out_instr
`ifdef IMM_ILLEGAL_CNT_EN
   ,
   output logic [15:0]     illegal_cnt
`endif
);
   localparam int DW = $bits(dec_t);
   localparam int W  = 32 + DW;

   dec_t         w_dec;
   dec_t         w_head;
   logic [W-1:0] w_rd_data;
   logic         w_push;

   assign w_dec  = imm_decode(in_instr);
   assign w_push = in_valid && in_ready && !flush;

   imm_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (sysclk),
      .rst_n      (rst_n),
      .i_flush    (flush),
      .i_wr_valid (in_valid),
      .o_wr_ready (in_ready),
      .i_wr_data  ({in_instr, w_dec}),
      .o_rd_valid (out_valid),
      .i_rd_ready (out_ready),
      .o_rd_data  (w_rd_data)
   );

   assign w_head      = w_rd_data[DW-1:0];
   assign out_instr   = w_rd_data[W-1:DW];
   assign out_fmt     = w_head.fmt;
   assign out_illegal = w_head.illegal;

   // imm[31] already equals instr[31] (or 0 for zero-imm formats).
   generate
      if (XLEN > 32) begin : g_sext
         assign out_imm = {{(XLEN-32){w_head.imm[31]}}, w_head.imm};
      end else begin : g_nosext
         assign out_imm = w_head.imm;
      end
   endgenerate

`ifdef IMM_ILLEGAL_CNT_EN
   logic [15:0] r_illegal_cnt;

   // Counts accepted pushes only; flush does not clear it.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_cnt <= 16'h0;
      end else if (w_push && w_dec.illegal && (r_illegal_cnt != 16'hFFFF)) begin
         r_illegal_cnt <= r_illegal_cnt + 16'd1;
      end
   end

   assign illegal_cnt = r_illegal_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_q.sv
`default_nettype none
// =============================================================================
//  Module   : tb_imm_decode_q
//  Purpose  : Self-checking bench for imm_decode_q. Directed scenarios plus a
//             randomized run compared against a queue-based reference model
//             whose decode is computed arithmetically from the RV32I rules.
//  Revision : 1.0  initial release
// =============================================================================
module tb_imm_decode_q;
   import imm_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic            sysclk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   fmt_t            out_fmt;
   logic            out_illegal;
   logic [31:0]     out_instr;
`ifdef IMM_ILLEGAL_CNT_EN
   logic [15:0]     illegal_cnt;
`endif

   imm_decode_q #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal),
      .out_instr   (out_instr)
`ifdef IMM_ILLEGAL_CNT_EN
      ,
      .illegal_cnt (illegal_cnt)
`endif
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // ---------------- reference model ----------------
   logic [31:0] mq[$];
   logic [31:0] last_head;
   bit          last_is_reset;
   logic [15:0] mcnt;

   // Immediate computed with signed arithmetic rather than bit concatenation.
   function automatic void ref_dec(input logic [31:0] i, output logic [31:0] imm,
                                   output fmt_t fmt, output bit ill);
      int s;
      int hi;
      s   = $signed(i);
      hi  = s >>> 31;
      imm = 32'h0;
      fmt = FMT_NONE;
      ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: begin fmt = FMT_I; imm = s >>> 20; end
         7'h23: begin
            fmt = FMT_S;
            imm = hi * 4096 + i[31:25] * 32 + i[11:7];
         end
         7'h63: begin
            fmt = FMT_B;
            imm = hi * 4096 + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2;
         end
         7'h37, 7'h17: begin fmt = FMT_U; imm = i & 32'hFFFFF000; end
         7'h6F: begin
            fmt = FMT_J;
            imm = hi * 1048576 + i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2;
         end
         7'h33: fmt = FMT_R;
         default: ill = 1'b1;
      endcase
   endfunction

   function automatic void model_reset();
      mq.delete();
      last_head     = 32'h0;
      last_is_reset = 1'b1;
      mcnt          = 16'h0;
   endfunction

   // Advance model by one edge using the currently driven inputs, then clock.
   task automatic tick();
      bit          do_push;
      bit          do_pop;
      logic [31:0] imm;
      fmt_t        f;
      bit          ill;
      if (flush) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() > 0) && out_ready;
         do_push = in_valid && (mq.size() < DEPTH);
         ref_dec(in_instr, imm, f, ill);
         if (do_push && ill && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(in_instr);
      end
      @(posedge sysclk);
      #1;
      if (mq.size() > 0) begin
         last_head     = mq[0];
         last_is_reset = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      flush = 0; in_valid = 0; in_instr = 0; out_ready = 0;
      rst_n = 1;
      #1 rst_n = 0;
      #2;
      chk_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL reset_handshake: got v/r=%b%b exp 01", out_valid, in_ready);
      else pass_cnt++;
      chk_cnt++;
      if ({out_imm, out_fmt, out_illegal, out_instr} !== '0)
         $display("FAIL reset_head: got imm=%h fmt=%0d ill=%b instr=%h exp zeros",
                  out_imm, out_fmt, out_illegal, out_instr);
      else pass_cnt++;
      repeat (2) @(posedge sysclk);
      @(negedge sysclk) rst_n = 1;
      @(posedge sysclk);
      #1;
      model_reset();
   endtask

   task automatic test_addi();
      in_valid = 1; in_instr = 32'hFFF00093;
      tick();
      in_valid = 0;
      chk_cnt++;
      if ({out_valid, out_imm, out_fmt} !== {1'b1, 32'hFFFFFFFF, FMT_I})
         $display("FAIL addi: got v=%b imm=%h fmt=%0d exp 1 ffffffff %0d",
                  out_valid, out_imm, out_fmt, FMT_I);
      else pass_cnt++;
      out_ready = 1;
      tick();
      out_ready = 0;
      chk_cnt++;
      if ({out_valid, out_instr} !== {1'b0, 32'hFFF00093})
         $display("FAIL addi_hold: got v=%b instr=%h exp 0 fff00093", out_valid, out_instr);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w   [3] = '{32'hFE000EE3, 32'h123450B7, 32'h0000006F};
      logic [31:0] ei  [3] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000000};
      fmt_t        ef  [3] = '{FMT_B, FMT_U, FMT_J};
      out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_instr = w[k];
         tick();
         chk_cnt++;
         if ({out_valid, out_imm, out_fmt} !== {1'b1, ei[k], ef[k]})
            $display("FAIL b2b_%0d: got v=%b imm=%h fmt=%0d exp 1 %h %0d",
                     k, out_valid, out_imm, out_fmt, ei[k], ef[k]);
         else pass_cnt++;
      end
      in_valid = 0;
      tick();
      out_ready = 0;
      chk_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL b2b_drain: got v=%b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_full();
      logic [31:0] w[5] = '{32'h00100093, 32'h00200113, 32'h00300193,
                            32'h00400213, 32'h00500293};
      out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1; in_instr = w[k];
         tick();
      end
      in_instr = w[4];
      chk_cnt++;
      if ({in_ready, out_instr} !== {1'b0, w[0]})
         $display("FAIL full_ready: got r=%b head=%h exp 0 %h", in_ready, out_instr, w[0]);
      else pass_cnt++;
      tick();   // fifth word refused
      chk_cnt++;
      if ({in_ready, out_instr} !== {1'b0, w[0]})
         $display("FAIL full_hold: got r=%b head=%h exp 0 %h", in_ready, out_instr, w[0]);
      else pass_cnt++;
      out_ready = 1;
      tick();   // pop only, push still refused this edge
      out_ready = 0;
      chk_cnt++;
      if ({in_ready, out_instr} !== {1'b1, w[1]})
         $display("FAIL full_pop: got r=%b head=%h exp 1 %h", in_ready, out_instr, w[1]);
      else pass_cnt++;
      tick();   // fifth word accepted
      in_valid = 0;
      chk_cnt++;
      if (in_ready !== 1'b0)
         $display("FAIL full_refill: got r=%b exp 0", in_ready);
      else pass_cnt++;
      out_ready = 1;
      for (int k = 1; k < 5; k++) begin
         chk_cnt++;
         if ({out_valid, out_instr} !== {1'b1, w[k]})
            $display("FAIL full_order_%0d: got v=%b instr=%h exp 1 %h",
                     k, out_valid, out_instr, w[k]);
         else pass_cnt++;
         tick();
      end
      out_ready = 0;
   endtask

   task automatic test_illegal();
`ifdef IMM_ILLEGAL_CNT_EN
      logic [15:0] c0;
      c0 = illegal_cnt;
`endif
      in_valid = 1; in_instr = 32'h0000007F;
      tick();
      in_valid = 0;
      chk_cnt++;
      if ({out_valid, out_illegal, out_imm, out_fmt} !== {2'b11, 32'h0, FMT_NONE})
         $display("FAIL illegal: got v=%b ill=%b imm=%h fmt=%0d exp 1 1 0 0",
                  out_valid, out_illegal, out_imm, out_fmt);
      else pass_cnt++;
`ifdef IMM_ILLEGAL_CNT_EN
      chk_cnt++;
      if (illegal_cnt !== c0 + 16'd1)
         $display("FAIL illegal_cnt: got %h exp %h", illegal_cnt, c0 + 16'd1);
      else pass_cnt++;
`endif
      out_ready = 1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_flush();
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_instr = 32'h00000013 | (k << 20);
         tick();
      end
      flush = 1; in_valid = 1; in_instr = 32'h00700393;
      tick();
      flush = 0; in_valid = 0;
      chk_cnt++;
      if ({out_valid, in_ready, out_instr} !== {2'b01, 32'h00000013})
         $display("FAIL flush: got v=%b r=%b instr=%h exp 0 1 00000013",
                  out_valid, in_ready, out_instr);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (out_valid !== 1'b0)
         $display("FAIL flush_noaccept: got v=%b exp 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_instr = 32'h00100093 + (k << 20);
         tick();
      end
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      chk_cnt++;
      if ({out_valid, in_ready, out_instr} !== {2'b01, 32'h0})
         $display("FAIL async_reset: got v=%b r=%b instr=%h exp 0 1 0",
                  out_valid, in_ready, out_instr);
      else pass_cnt++;
      @(posedge sysclk);
      @(negedge sysclk) rst_n = 1;
      @(posedge sysclk);
      #1;
      model_reset();
      in_valid = 1; in_instr = 32'hFE112E23;   // sw x1,-4(x2)
      tick();
      in_valid = 0;
      chk_cnt++;
      if ({out_valid, out_imm, out_fmt, out_instr} !== {1'b1, 32'hFFFFFFFC, FMT_S, 32'hFE112E23})
         $display("FAIL async_resume: got v=%b imm=%h fmt=%0d instr=%h exp 1 fffffffc %0d fe112e23",
                  out_valid, out_imm, out_fmt, out_instr, FMT_S);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                               7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
      logic [31:0] e_instr;
      logic [31:0] e_imm;
      fmt_t        e_fmt;
      bit          e_ill;
      logic [31:0] r;
      for (int n = 0; n < 400; n++) begin
         e_instr = (mq.size() > 0) ? mq[0] : last_head;
         if (mq.size() == 0 && last_is_reset) begin
            e_imm = 0; e_fmt = FMT_NONE; e_ill = 0;
         end else begin
            ref_dec(e_instr, e_imm, e_fmt, e_ill);
         end
         chk_cnt++;
         if ({out_valid, in_ready} !== {mq.size() > 0, mq.size() < DEPTH})
            $display("FAIL rnd_hs_%0d: got v/r=%b%b exp %b%b", n, out_valid, in_ready,
                     mq.size() > 0, mq.size() < DEPTH);
         else pass_cnt++;
         chk_cnt++;
         if ({out_instr, out_imm, out_fmt, out_illegal} !== {e_instr, e_imm, e_fmt, e_ill})
            $display("FAIL rnd_head_%0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", n,
                     out_instr, out_imm, out_fmt, out_illegal, e_instr, e_imm, e_fmt, e_ill);
         else pass_cnt++;
`ifdef IMM_ILLEGAL_CNT_EN
         chk_cnt++;
         if (illegal_cnt !== mcnt)
            $display("FAIL rnd_cnt_%0d: got %h exp %h", n, illegal_cnt, mcnt);
         else pass_cnt++;
`endif
         r = $urandom;
         if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 9)];
         in_instr  = r;
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         tick();
      end
      flush = 0; in_valid = 0; out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_full();
      test_illegal();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
